// File: rtl/mult_seq_radix.sv
// ----------------------------------------------------------------------------
// mult_seq_radix
//   Sequential N x N multiplier that retires R multiplier bits per cycle and
//   produces an exact 2N-bit product. Signed operands are handled by
//   multiplying magnitudes and negating the result in a final FIX cycle.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-low reset
//     in_valid   operands valid            in_ready   block can accept operands
//     a, b       multiplicand / multiplier (N bits)
//     is_signed  1 = two's-complement operands, sampled with a/b
//     out_valid  prod valid                out_ready  consumer accepts prod
//     prod       2N-bit product, held until the next FIX cycle
//     busy       high whenever the FSM is not in IDLE
//
//   Optional feature
//     MULT_EARLY_TERM_EN : leave RUN as soon as the remaining multiplier bits
//                          are all zero (at least one RUN cycle is executed).
// ----------------------------------------------------------------------------
module mult_seq_radix #(
    parameter int N = 256,
    parameter int R = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] prod,
    output logic           busy
);

    localparam int STEPS = N / R;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    generate
        if (N < 4 || R < 1 || R > 8 || (N % R) != 0) begin : g_bad_cfg
            $error("mult_seq_radix: illegal parameters N=%0d R=%0d", N, R);
        end
    endgenerate

    logic [1:0]     state_q,  state_d;
    logic [2*N-1:0] acc_q,    acc_d;
    logic [2*N-1:0] mcand_q,  mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  count_q,  count_d;
    logic           neg_q,    neg_d;
    logic [2*N-1:0] prod_q,   prod_d;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [2*N-1:0] pp;
    logic [N-1:0]   mplier_nxt;
    logic           run_last;

    always_comb begin
        // Magnitudes fit in N unsigned bits, including |-2^(N-1)| = 2^(N-1).
        a_mag = (is_signed && a[N-1]) ? (~a + N'(1)) : a;
        b_mag = (is_signed && b[N-1]) ? (~b + N'(1)) : b;

        // R-bit slice of the multiplier times the multiplicand.
        pp = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (mplier_q[i]) pp = pp + (mcand_q << i);
        end

        mplier_nxt = mplier_q >> R;

`ifdef MULT_EARLY_TERM_EN
        run_last = (count_q == CW'(STEPS - 1)) || (mplier_nxt == '0);
`else
        run_last = (count_q == CW'(STEPS - 1));
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        neg_d    = neg_q;
        prod_d   = prod_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{N{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = is_signed & (a[N-1] ^ b[N-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << R;
                mplier_d = mplier_nxt;
                count_d  = count_q + CW'(1);
                if (run_last) state_d = S_FIX;
            end
            S_FIX: begin
                prod_d  = neg_q ? (~acc_q + (2*N)'(1)) : acc_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
        end
    end

    // Handshake outputs decode the state register only: no input-to-output path.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign prod      = prod_q;

endmodule

// File: tb/tb_mult_seq_radix.sv
module tb_mult_seq_radix;

`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Wide instance: N=256, R=2
    logic         w_rst, w_iv, w_ir, w_sg, w_ov, w_or, w_busy;
    logic [255:0] w_a, w_b;
    logic [511:0] w_p;
    mult_seq_radix #(.N(256), .R(2)) u_w (
        .clk(clk), .rst(w_rst), .in_valid(w_iv), .in_ready(w_ir), .a(w_a), .b(w_b),
        .is_signed(w_sg), .out_valid(w_ov), .out_ready(w_or), .prod(w_p), .busy(w_busy));

    // Small instances share one reset: N=8 R=1 and N=8 R=4
    logic         n_rst;
    logic         s_iv, s_ir, s_sg, s_ov, s_or, s_busy;
    logic [7:0]   s_a, s_b;
    logic [15:0]  s_p;
    mult_seq_radix #(.N(8), .R(1)) u_s (
        .clk(clk), .rst(n_rst), .in_valid(s_iv), .in_ready(s_ir), .a(s_a), .b(s_b),
        .is_signed(s_sg), .out_valid(s_ov), .out_ready(s_or), .prod(s_p), .busy(s_busy));

    logic         k_iv, k_ir, k_sg, k_ov, k_or, k_busy;
    logic [7:0]   k_a, k_b;
    logic [15:0]  k_p;
    mult_seq_radix #(.N(8), .R(4)) u_k (
        .clk(clk), .rst(n_rst), .in_valid(k_iv), .in_ready(k_ir), .a(k_a), .b(k_b),
        .is_signed(k_sg), .out_valid(k_ov), .out_ready(k_or), .prod(k_p), .busy(k_busy));

    // ---------------- reference model ----------------
    // Exact product of n-bit operands, as a 2n-bit two's-complement/unsigned value.
    function automatic logic [511:0] ref_mul(input logic [255:0] a, input logic [255:0] b,
                                             input logic s, input int n);
        logic [511:0] ax, bx, ones, mask;
        ones = '1;
        ax = {256'b0, a};
        bx = {256'b0, b};
        if (s && a[n-1]) ax = ax | (ones << n);
        if (s && b[n-1]) bx = bx | (ones << n);
        mask = (2 * n >= 512) ? ones : ~(ones << (2 * n));
        return (ax * bx) & mask;
    endfunction

    // Edges from accept to out_valid high.
    function automatic int exp_lat(input logic [255:0] b, input logic s, input int n, input int r);
        logic [255:0] m, ones;
        int bl, runs_et;
        ones = '1;
        m = b;
        if (s && b[n-1]) m = (~b + 256'd1) & ~(ones << n);
        bl = 0;
        for (int i = 0; i < n; i++) if (m[i]) bl = i + 1;
        runs_et = (bl == 0) ? 1 : (bl + r - 1) / r;
        return (EARLY ? runs_et : n / r) + 2;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic op_w(input logic [255:0] a, input logic [255:0] b, input logic s,
                        output logic [511:0] p, output int lat, output int unsigned acc_at);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!w_ir && guard < 400) begin @(negedge clk); guard++; end
        n_tests++;
        if (w_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL w_accept_wait: in_ready=%0b required 1", w_ir);
        end
        w_a = a; w_b = b; w_sg = s; w_iv = 1'b1;
        @(posedge clk); #1;
        acc_at = cyc;
        w_iv = 1'b0;
        lat = 1;
        while (!w_ov && lat < 400) begin @(posedge clk); #1; lat++; end
        p = w_p;
    endtask

    task automatic op_s(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] p, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!s_ir && guard < 50) begin @(negedge clk); guard++; end
        n_tests++;
        if (s_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL s_accept_wait: in_ready=%0b required 1", s_ir);
        end
        s_a = a; s_b = b; s_sg = s; s_iv = 1'b1;
        @(posedge clk); #1;
        s_iv = 1'b0;
        lat = 1;
        while (!s_ov && lat < 50) begin @(posedge clk); #1; lat++; end
        p = s_p;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        w_rst = 1'b0; n_rst = 1'b0;
        w_iv = 1'b0; s_iv = 1'b0; k_iv = 1'b0;
        w_or = 1'b1; s_or = 1'b1; k_or = 1'b1;
        w_a = '0; w_b = '0; w_sg = 1'b0;
        s_a = '0; s_b = '0; s_sg = 1'b0;
        k_a = '0; k_b = '0; k_sg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({w_ir, w_ov, w_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_w_hs: {ir,ov,busy}=%b required 100", {w_ir, w_ov, w_busy});
        end
        n_tests++;
        if (w_p !== '0) begin n_fail++; $display("FAIL reset_w_prod: prod=%h required 0", w_p); end
        n_tests++;
        if ({s_ir, s_ov, s_busy, s_p} !== {3'b100, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_s: {ir,ov,busy}=%b prod=%h required 100/0", {s_ir, s_ov, s_busy}, s_p);
        end
        n_tests++;
        if ({k_ir, k_ov, k_busy, k_p} !== {3'b100, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_k: {ir,ov,busy}=%b prod=%h required 100/0", {k_ir, k_ov, k_busy}, k_p);
        end
        @(negedge clk);
        w_rst = 1'b1; n_rst = 1'b1;
    endtask

    task automatic test_unsigned_wide();
        logic [255:0] ta [6];
        logic [255:0] tb [6];
        logic [255:0] ones;
        logic [511:0] p, e, hard;
        int lat;
        int unsigned at;
        ones = '1;
        ta[0] = 256'd5;  tb[0] = 256'd12;
        ta[1] = ones;    tb[1] = 256'd2;
        ta[2] = ones;    tb[2] = ones;
        ta[3] = 256'd3;  tb[3] = 256'd1;
        ta[4] = 256'd3;  tb[4] = 256'd0;
        ta[5] = 256'd3;  tb[5] = 256'd1 << 255;
        for (int i = 0; i < 6; i++) begin
            op_w(ta[i], tb[i], 1'b0, p, lat, at);
            e = ref_mul(ta[i], tb[i], 1'b0, 256);
            n_tests++;
            if (p !== e) begin n_fail++; $display("FAIL wide_u%0d_prod: got %h required %h", i, p, e); end
            n_tests++;
            if (lat !== exp_lat(tb[i], 1'b0, 256, 2)) begin
                n_fail++;
                $display("FAIL wide_u%0d_lat: got %0d required %0d", i, lat, exp_lat(tb[i], 1'b0, 256, 2));
            end
            if (i == 2) begin
                hard = {ones - 256'd1, 256'd1};
                n_tests++;
                if (p !== hard) begin n_fail++; $display("FAIL wide_max_sq: got %h required %h", p, hard); end
            end
        end
    endtask

    task automatic test_signed_small();
        logic [7:0]  da [3] = '{8'hfd, 8'h80, 8'h80};
        logic [7:0]  db [3] = '{8'h05, 8'h80, 8'h01};
        logic [15:0] de [3] = '{16'hfff1, 16'h4000, 16'hff80};
        logic [15:0] p;
        logic [511:0] e;
        logic [7:0] ra, rb;
        logic rs;
        int lat;
        for (int i = 0; i < 3; i++) begin
            op_s(da[i], db[i], 1'b1, p, lat);
            n_tests++;
            if (p !== de[i]) begin n_fail++; $display("FAIL s_dir%0d_prod: got %h required %h", i, p, de[i]); end
            n_tests++;
            if (lat !== exp_lat({248'b0, db[i]}, 1'b1, 8, 1)) begin
                n_fail++;
                $display("FAIL s_dir%0d_lat: got %0d required %0d", i, lat, exp_lat({248'b0, db[i]}, 1'b1, 8, 1));
            end
        end
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            op_s(ra, rb, rs, p, lat);
            e = ref_mul({248'b0, ra}, {248'b0, rb}, rs, 8);
            n_tests++;
            if (p !== e[15:0] || lat !== exp_lat({248'b0, rb}, rs, 8, 1)) begin
                n_fail++;
                $display("FAIL s_rand%0d: a=%h b=%h s=%0b prod=%h lat=%0d required %h lat=%0d",
                         i, ra, rb, rs, p, lat, e[15:0], exp_lat({248'b0, rb}, rs, 8, 1));
            end
        end
    endtask

    task automatic test_random_wide();
        logic [255:0] ra, rb;
        logic rs;
        logic [511:0] p, e;
        int lat;
        int unsigned at;
        for (int i = 0; i < 4; i++) begin
            ra = rand256(); rb = rand256(); rs = 1'($urandom);
            if (i == 3) rb = 256'($urandom_range(1, 5000));
            if (i == 1) begin ra = 256'd1 << 255; rs = 1'b1; end
            op_w(ra, rb, rs, p, lat, at);
            e = ref_mul(ra, rb, rs, 256);
            n_tests++;
            if (p !== e) begin n_fail++; $display("FAIL wide_rand%0d_prod: got %h required %h", i, p, e); end
            n_tests++;
            if (lat !== exp_lat(rb, rs, 256, 2)) begin
                n_fail++;
                $display("FAIL wide_rand%0d_lat: got %0d required %0d", i, lat, exp_lat(rb, rs, 256, 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] b1;
        logic [511:0] p;
        int lat1, lat2;
        int unsigned at1, at2;
        b1 = rand256();
        op_w(rand256(), b1, 1'b0, p, lat1, at1);
        op_w(rand256(), rand256(), 1'b1, p, lat2, at2);
        n_tests++;
        if (int'(at2 - at1) !== exp_lat(b1, 1'b0, 256, 2) + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d required %0d", at2 - at1, exp_lat(b1, 1'b0, 256, 2) + 1);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int guard;
        k_or = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!k_ir && guard < 50) begin @(negedge clk); guard++; end
        k_a = 8'hff; k_b = 8'hff; k_sg = 1'b0; k_iv = 1'b1;
        @(posedge clk); #1;
        k_iv = 1'b0;
        lat = 1;
        while (!k_ov && lat < 50) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (lat !== exp_lat(256'hff, 1'b0, 8, 4)) begin
            n_fail++;
            $display("FAIL bp_lat: got %0d required %0d", lat, exp_lat(256'hff, 1'b0, 8, 4));
        end
        n_tests++;
        if (k_p !== 16'hfe01) begin n_fail++; $display("FAIL bp_prod: got %h required fe01", k_p); end
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin k_a = 8'h01; k_b = 8'h01; k_iv = 1'b1; end
            @(posedge clk); #1;
            n_tests++;
            if (k_ov !== 1'b1 || k_p !== 16'hfe01 || k_ir !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall%0d: ov=%0b ir=%0b prod=%h required 1/0/fe01", c, k_ov, k_ir, k_p);
            end
        end
        k_or = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (k_ir !== 1'b1 || k_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: ir=%0b ov=%0b required 1/0", k_ir, k_ov);
        end
        k_iv = 1'b0;
        n_tests++;
        if (k_p !== 16'hfe01) begin n_fail++; $display("FAIL bp_prod_keep: got %h required fe01", k_p); end
        @(posedge clk); #1;
        n_tests++;
        if (k_busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept: busy=%0b required 0", k_busy); end
    endtask

    task automatic test_reset_midop();
        logic [511:0] p;
        int lat;
        int unsigned at;
        @(negedge clk);
        w_a = rand256(); w_b = rand256() | (256'd1 << 255); w_sg = 1'b0; w_iv = 1'b1;
        @(posedge clk); #1;
        w_iv = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        w_rst = 1'b0;
        #1;
        n_tests++;
        if ({w_ir, w_ov, w_busy} !== 3'b100 || w_p !== '0) begin
            n_fail++;
            $display("FAIL midop_reset: {ir,ov,busy}=%b prod=%h required 100/0", {w_ir, w_ov, w_busy}, w_p);
        end
        @(negedge clk);
        w_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (w_ov !== 1'b0 || w_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_aborted: ov=%0b busy=%0b required 0/0", w_ov, w_busy);
        end
        op_w(256'd7, 256'd9, 1'b0, p, lat, at);
        n_tests++;
        if (p !== 512'd63) begin n_fail++; $display("FAIL midop_next_prod: got %h required 3f", p); end
        n_tests++;
        if (lat !== exp_lat(256'd9, 1'b0, 256, 2)) begin
            n_fail++;
            $display("FAIL midop_next_lat: got %0d required %0d", lat, exp_lat(256'd9, 1'b0, 256, 2));
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_wide();
        test_signed_small();
        test_random_wide();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_seq_radix.md
Name: mult_seq_radix

Overview:
- Parametrised sequential N x N multiplier. Consumes R multiplier bits per cycle and produces an exact 2N-bit product.
- Successor to the fixed 256-bit shift-add multiplier. Adds:
  - valid/ready handshakes on input and output;
  - a per-operation signed/unsigned mode;
  - a configurable radix.
- Sits between the field-arithmetic sequencer and the reduction stage. The downstream stage may stall via out_ready.

Parameters:
- N, 256, operand width in bits. N >= 4.
- R, 2, multiplier bits retired per cycle. 1 <= R <= 8; N % R == 0. Elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  N  multiplicand
- b  input  N  multiplier
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- out_valid  output  1  prod valid
- out_ready  input  1  consumer accepts prod
- prod  output  2N  product
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; in_ready=1, out_valid=0, busy=0, prod=0.
  - Internal acc, multiplicand, multiplier, count and sign registers cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - if is_signed, capture |a| and |b|, else a and b, zero-extended into the 2N-bit multiplicand register and the N-bit multiplier register;
    - neg = is_signed & (a[N-1]^b[N-1]);
    - acc=0, count=0; go to RUN.
  - in_ready=0 in all other states. Operands are not re-sampled until the next IDLE.
- Signed edge case: |-2^(N-1)| = 2^(N-1). Magnitudes are held in N bits unsigned, so the result stays exact.
- RUN, each cycle:
  - acc += multiplicand * multiplier[R-1:0], with a 2N-bit add (no overflow is possible);
  - multiplicand <<= R; multiplier >>= R; count++.
  - After N/R RUN cycles, go to FIX.
- FIX (one cycle): prod <= neg ? (~acc + 1) : acc, truncated to 2N bits; go to DONE.
- DONE:
  - out_valid=1.
  - prod is held stable while out_valid & !out_ready, for any number of cycles.
  - On out_valid & out_ready: go to IDLE, out_valid=0 next cycle. prod keeps its last value until the next FIX.
- Latency:
  - Accept edge to out_valid high = N/R+2 edges: 1 capture, N/R RUN, 1 FIX. N=256, R=2 gives 130.
  - Throughput: one operation per N/R+3 cycles with out_ready tied high (returns to IDLE before the next accept).
- No combinational path from in_valid/out_ready to in_ready/out_valid; all handshake outputs are registered.
- in_valid while busy is ignored. The source must hold its operands until in_ready.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - in RUN, if the multiplier register (after the current shift) is zero, go to FIX on that edge; otherwise continue as normal;
  - if b (magnitude) = 0 at accept, exactly one RUN cycle is still executed;
  - latency becomes ceil(bitlen(|b|)/R)+2 edges, minimum 3.
- Undefined: fixed N/R+2 latency for all operands; no zero-detect logic is synthesised.

Test Plan:
- N=256, R=2, unsigned, a=5, b=12; out_ready=1 -> prod=0x3c; out_valid rises exactly 130 edges after accept (macro off).
- N=256, R=2, unsigned, a='1, b=2 -> prod=0x1_ffff...fffe (2N bits, 257 significant bits). Then a='1, b='1 -> prod=0xffff...fffe_0000...0001 (upper half 2^256-2, lower half 1).
- N=8, R=1, signed, a=0xfd (-3), b=0x05 -> prod=0xfff1. Also a=0x80, b=0x80 -> prod=0x4000, and a=0x80, b=0x01 -> prod=0xff80.
- Backpressure, N=8, R=4, a=0xff, b=0xff unsigned -> prod=0xfe01:
  - hold out_ready=0 for 20 cycles; out_valid and prod stay stable and in_ready stays 0;
  - a second in_valid during the stall is not accepted;
  - on out_ready=1, in_ready returns 1 on the following cycle.
- Reset mid-op, N=256, R=2: assert rst=0 asynchronously (between clock edges) 50 cycles into RUN -> outputs take their reset values immediately; after release, a new op a=7, b=9 yields prod=63 with full latency.
- MULT_EARLY_TERM_EN defined, N=256, R=2, a=3, b=1 -> prod=3, out_valid 3 edges after accept. b=0 -> prod=0, 3 edges. b=2^255 -> full 130 edges.
